// File: rtl/guitar_pkg.sv
// Shared constants and helpers for the note-row strike-line scorer.
// Row geometry: SLOTS slots of LANES lane flags, slot k in bits [k*LANES +: LANES],
// lane 0 is the LSB of its slot. LANES*SLOTS must equal ROW_BITS.
package guitar_pkg;

  localparam int unsigned LANES       = 5;
  localparam int unsigned SLOTS       = 6;
  localparam int unsigned ROW_BITS    = 30;
  localparam int unsigned HIT_PTS_DEF = 10;

  // Slot extraction: stride between slots in the row word
  localparam int unsigned SLOT_STRIDE = LANES;
  // Pointer wide enough to hold 0..SLOTS; SLOTS itself means idle/empty
  localparam int unsigned PTR_W       = 3;
  localparam int unsigned IDLE_PTR    = SLOTS;
  // Width of a per-slot hit count (0..LANES)
  localparam int unsigned CNT_W       = 3;

  typedef logic [LANES-1:0]    lanes_t;
  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [PTR_W-1:0]    ptr_t;

  // Lane flags of slot p; all-zero for the idle pointer
  function automatic lanes_t slot_of(input row_t row, input ptr_t p);
    lanes_t r;
    r = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (p == PTR_W'(k)) r = row[k*SLOT_STRIDE +: LANES];
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input lanes_t v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < LANES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/note_hit_scorer_btn_edge.sv
// btn_edge: per-lane rising-edge detector.
// Ports: CLK, RST (sync, active-high), BTN (button levels), press_c (BTN & ~previous BTN).
// The history is registered; the press vector is combinational from it so the
// scorer can judge and register results on the very next edge.
module btn_edge #(
  parameter int unsigned W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] BTN,
  output logic [W-1:0] press_c
);

  logic [W-1:0] btn_prev;

  // Button history
  always_ff @(posedge CLK) begin
    if (RST) btn_prev <= '0;
    else     btn_prev <= BTN;
  end

  assign press_c = BTN & ~btn_prev;

endmodule

// File: rtl/note_hit_scorer.sv
// note_hit_scorer: judges button presses against the delayed note row at the
// strike line, walking one slot per TICK, and keeps score/combo for the UI.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   ROW_IN/ROW_STB  framed note row and its one-cycle load strobe
//   TICK            one-cycle slot-advance pulse
//   BTN             synchronized, debounced button levels (one per lane)
//   SCORE, COMBO    saturating score and consecutive-hit count
//   HIT_PULSE       one cycle: at least one hit judged
//   MISS_PULSE      one cycle: at least one miss or wrong press
//   UNDERRUN        sticky: TICK arrived with no slot left to walk
// Build option: define MULTIPLIER_EN to scale per-hit points by
// 1+min(COMBO/10,3) using the pre-update COMBO.
module note_hit_scorer
  import guitar_pkg::*;
#(
  parameter int unsigned HIT_PTS = HIT_PTS_DEF,
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned COMBO_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ROW_BITS-1:0] ROW_IN,
  input  logic                ROW_STB,
  input  logic                TICK,
  input  logic [LANES-1:0]    BTN,
  output logic [SCORE_W-1:0]  SCORE,
  output logic [COMBO_W-1:0]  COMBO,
  output logic                HIT_PULSE,
  output logic                MISS_PULSE,
  output logic                UNDERRUN
);

  localparam int unsigned SSUM_W = SCORE_W + 32;
  localparam int unsigned CSUM_W = COMBO_W + CNT_W;

  row_t   row_buf;
  ptr_t   ptr;
  lanes_t hit_mask;

  lanes_t press_c, slot_c, pend_c, hits_c, wrong_c, missed_c;
  logic   idle_c;
  logic [CNT_W-1:0]   n_hits_c;
  logic [31:0]        add_c;
  logic [SSUM_W-1:0]  ssum_c;
  logic [CSUM_W-1:0]  csum_c;
  logic [SCORE_W-1:0] score_next_c;
  logic [COMBO_W-1:0] combo_next_c;

  btn_edge #(.W(LANES)) u_btn_edge (
    .CLK     (CLK),
    .RST     (RST),
    .BTN     (BTN),
    .press_c (press_c)
  );

  // Judge this cycle's presses against the current (pre-advance) slot
  always_comb begin
    idle_c   = (ptr == PTR_W'(IDLE_PTR));
    slot_c   = slot_of(row_buf, ptr);
    pend_c   = slot_c & ~hit_mask;
    hits_c   = press_c & pend_c;
    // Presses with no row loaded are ignored rather than judged wrong
    wrong_c  = idle_c ? '0 : (press_c & ~pend_c);
    missed_c = TICK ? (pend_c & ~hits_c) : '0;
    n_hits_c = popcount(hits_c);
  end

  // Points earned this cycle
`ifdef MULTIPLIER_EN
  logic [2:0] mult_c;
  always_comb begin
    mult_c = 3'd1;
    if      (32'(COMBO) >= 32'd30) mult_c = 3'd4;
    else if (32'(COMBO) >= 32'd20) mult_c = 3'd3;
    else if (32'(COMBO) >= 32'd10) mult_c = 3'd2;
    add_c = 32'(n_hits_c) * 32'(HIT_PTS) * 32'(mult_c);
  end
`else
  always_comb begin
    add_c = 32'(n_hits_c) * 32'(HIT_PTS);
  end
`endif

  // Saturating score and combo; wrong presses and misses break the combo
  // after the hits have been added
  always_comb begin
    ssum_c       = SSUM_W'(SCORE) + SSUM_W'(add_c);
    score_next_c = (ssum_c[SSUM_W-1:SCORE_W] != '0) ? '1 : SCORE_W'(ssum_c);
    csum_c       = CSUM_W'(COMBO) + CSUM_W'(n_hits_c);
    combo_next_c = (csum_c[CSUM_W-1:COMBO_W] != '0) ? '1 : COMBO_W'(csum_c);
    if ((wrong_c != '0) || (missed_c != '0)) combo_next_c = '0;
  end

  // Row buffer, slot walk and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_buf    <= '0;
      ptr        <= PTR_W'(IDLE_PTR);
      hit_mask   <= '0;
      SCORE      <= '0;
      COMBO      <= '0;
      HIT_PULSE  <= 1'b0;
      MISS_PULSE <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      SCORE      <= score_next_c;
      COMBO      <= combo_next_c;
      HIT_PULSE  <= (hits_c != '0);
      MISS_PULSE <= (wrong_c != '0) || (missed_c != '0);
      if (TICK && idle_c) UNDERRUN <= 1'b1;

      // A new row always wins over the slot advance; leftover notes of the
      // old row are dropped silently
      if (ROW_STB) begin
        row_buf <= ROW_IN;
        ptr     <= '0;
      end else if (TICK && !idle_c) begin
        ptr     <= ptr + PTR_W'(1);
      end

      if (ROW_STB || TICK) hit_mask <= '0;
      else                 hit_mask <= hit_mask | hits_c;
    end
  end

endmodule

// File: doc/note_hit_scorer.md
Name: note_hit_scorer

Overview:
- Downstream consumer of the 30-bit note-row delay line; judges player button presses against delayed note rows at the strike line.
- Each framed row holds SLOTS time slots of LANES lane flags.
- Walks slots on a slot tick, registers hits, misses and wrong presses, and maintains score and combo for the display/UI stage.

Parameters:
- LANES, 5, lanes per slot (one button per lane).
- SLOTS, 6, slots per row; LANES*SLOTS must equal 30 (row width).
- HIT_PTS, 10, base points per hit note.
- SCORE_W, 16, score counter width.
- COMBO_W, 8, combo counter width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- ROW_IN  in  30  delayed note row from the shift-register output; slot k in bits [5k+4:5k], lane 0 = LSB of slot.
- ROW_STB  in  1  one-cycle strobe; ROW_IN is word-aligned and valid this cycle.
- TICK  in  1  one-cycle slot-advance pulse.
- BTN  in  LANES  synchronized, debounced button levels.
- SCORE  out  SCORE_W  accumulated score, saturating.
- COMBO  out  COMBO_W  consecutive-hit count, saturating.
- HIT_PULSE  out  1  one-cycle pulse: at least one hit judged.
- MISS_PULSE  out  1  one-cycle pulse: at least one note missed or wrong press.
- UNDERRUN  out  1  sticky: slot walk ran past the last slot before a new row arrived.

Behaviour:
- Reset: SCORE=0, COMBO=0, HIT_PULSE=0, MISS_PULSE=0, UNDERRUN=0, row buffer=0, slot pointer=SLOTS (idle/empty), button history=0.
- Edge detect: press = BTN & ~BTN_prev, registered per lane; a level held high never re-triggers.
- Pending notes: pend = row_buf slot[ptr] with hit lanes cleared; pend=0 when ptr==SLOTS.
- Per cycle, judge presses against the current (pre-advance) slot:
  - hits = press & pend;
  - wrong = press & ~pend;
  - clear hit lanes in pend.
- Scoring: SCORE += popcount(hits)*HIT_PTS, saturating at 2^SCORE_W-1.
- Combo:
  - COMBO += popcount(hits), saturating at 2^COMBO_W-1.
  - Any wrong bit forces COMBO=0 after adding the hits (hits still score).
- End of slot on TICK: missed = pend remaining after this cycle's hits.
  - If missed≠0: COMBO=0 and MISS_PULSE.
  - Then ptr advances by 1.
  - If ptr was SLOTS-1 and no ROW_STB, ptr becomes SLOTS.
  - TICK with ptr==SLOTS sets UNDERRUN; UNDERRUN clears only on RST.
- ROW_STB: load ROW_IN into the row buffer and set ptr=0.
  - Same cycle as TICK: old slot is judged and miss-evaluated first, then the load wins (ptr=0, not 1).
  - ROW_STB without TICK while slots of the old row are still pending: the old row's remaining notes are discarded without a miss.
- Latency: outputs are registered and update the cycle after the press edge or TICK; HIT_PULSE/MISS_PULSE are high for exactly one cycle.
- Multi-lane: several lanes judged in the same cycle are independent; a chord of 3 hits scores 3*HIT_PTS.
- RST mid-row: all state returns to reset values; the next judging starts at the next ROW_STB.

Optional Feature:
- MULTIPLIER_EN defined: per-hit points = HIT_PTS*(1+min(COMBO/10,3)), using COMBO before this cycle's update (max x4).
- Undefined: flat HIT_PTS per hit; no multiply logic.

Decomposition:
- Shared package guitar_pkg: LANES, SLOTS, ROW_BITS=30, HIT_PTS default, slot-extraction index constants, and an idle pointer constant equal to SLOTS.
- One natural sub-module: btn_edge (per-lane registered rising-edge detector, LANES wide, CLK/RST).

Test Plan:
- Reset check: RST 1 cycle, then idle 20 cycles, no ROW_STB, BTN pressed -> SCORE=0, COMBO=0, no pulses.
- Clean hit:
  - Stimulus: ROW_IN slot0=5'b00001, ROW_STB, BTN[0] rises before the first TICK.
  - Required: HIT_PULSE 1 cycle later, SCORE=10, COMBO=1.
  - Holding BTN[0] through further cycles adds nothing.
- Miss and wrong press:
  - Stimulus: slot0=5'b00011, press only lane 0, then TICK.
  - Required: SCORE=10, MISS_PULSE at TICK, COMBO=0.
  - Next slot empty plus press lane 4 -> MISS_PULSE, COMBO stays 0.
- Chord plus saturation:
  - Stimulus: slot=5'b11111, all lanes pressed in one cycle.
  - Required: SCORE+=50, COMBO+=5.
  - Preload SCORE near 65535 -> SCORE sticks at 65535.
  - Drive COMBO past 255 -> COMBO stays 255.
- Underrun/simultaneity:
  - Stimulus: 7 TICKs after one ROW_STB.
  - Required: UNDERRUN=1 and stays 1.
  - ROW_STB coincident with TICK -> old slot miss-evaluated, ptr=0 next cycle.
- MULTIPLIER_EN:
  - Stimulus: COMBO=10, one hit.
  - Required: SCORE+=20.
  - COMBO=35, one hit -> +40. Undefined build -> +10 each.
